ftdi245_bus: RTL
================

FTDI245_BUS -- requirements
Module: ftdi245_bus

Interface
REQ-001 The block SHALL provide these parameters, one per line:
  RD_PULSE  4  clk cycles ftdi_rd_n is held low (1..15)
  WR_PULSE  4  clk cycles ftdi_wr is held high (1..15)
  RECOVERY  2  clk cycles of bus idle after each strobe (1..15)
  TIMEOUT  1024  clk cycles before a stalled request aborts (used only with FTDI245_TIMEOUT_EN)
REQ-002 The block SHALL provide these ports, one per line:
  clk  in  1  single clock; all logic on rising edge
  rst_n  in  1  asynchronous, active-low reset
  cpu_rd_req  in  1  level; request one byte read from FT245
  cpu_wr_req  in  1  level; request one byte write to FT245
  cpu_wdata  in  8  byte to write
  cpu_rdata  out  8  last byte read, registered
  cpu_done  out  1  one-cycle pulse; transaction finished
  cpu_err  out  1  valid with cpu_done; 1 = aborted by timeout
  busy  out  1  1 whenever the FSM is not IDLE
  ftdi_rxf_n  in  1  FT245 RXF#, asynchronous
  ftdi_txe_n  in  1  FT245 TXE#, asynchronous
  ftdi_d_in  in  8  FT245 data bus input
  ftdi_d_out  out  8  FT245 data bus output
  ftdi_d_oe  out  1  data bus output enable
  ftdi_rd_n  out  1  FT245 RD#
  ftdi_wr  out  1  FT245 WR (active high, latches on falling edge)
  rxf  out  1  synchronized RXF#, active low, feeds interrupt generator
  txe  out  1  synchronized TXE#, active low, feeds interrupt generator
  data_wrh_n  out  1  low for one cycle when a write completes

Function
REQ-003 ftdi_rxf_n/ftdi_txe_n SHALL pass through a 2-flop synchronizer; rxf/txe are the second-flop outputs (2-cycle latency); the FSM uses only rxf/txe.
REQ-004 FSM states SHALL be IDLE, RD_STROBE, RD_RECOV, WR_SETUP, WR_STROBE, WR_RECOV.
REQ-005 IDLE->RD_STROBE SHALL occur when cpu_rd_req=1 and rxf=0; IDLE->WR_SETUP when cpu_wr_req=1, txe=0 and the read condition is false (read has priority when both are serviceable).
REQ-006 RD_STROBE SHALL drive ftdi_rd_n=0 for exactly RD_PULSE cycles; ftdi_d_in SHALL be captured into cpu_rdata on the last RD_STROBE cycle; then RD_RECOV for RECOVERY cycles with ftdi_rd_n=1.
REQ-007 WR_SETUP SHALL last 1 cycle with ftdi_d_out=cpu_wdata and ftdi_d_oe=1; WR_STROBE SHALL hold ftdi_wr=1 for WR_PULSE cycles; WR_RECOV SHALL hold ftdi_d_oe=1 on its first cycle only, then 0, for RECOVERY cycles total.
REQ-008 ftdi_d_out SHALL be registered at the IDLE->WR_SETUP transition and held stable until ftdi_d_oe falls.
REQ-009 cpu_done SHALL pulse on the cycle the FSM leaves RD_RECOV/WR_RECOV for IDLE; data_wrh_n SHALL pulse low in the same cycle for writes only.
REQ-010 A request still high in the cycle after cpu_done SHALL start a new transaction; requests SHALL NOT be aborted mid-strobe by deassertion.
REQ-011 Request with rxf=1 (read) or txe=1 (write) SHALL wait in IDLE with busy=0 until serviceable.
REQ-012 ftdi_rd_n=0 and ftdi_wr=1 SHALL never be asserted in the same cycle; ftdi_d_oe SHALL be 0 whenever ftdi_rd_n=0.

Reset
REQ-013 On rst_n=0, asynchronously: FSM=IDLE, counters=0, ftdi_rd_n=1, ftdi_wr=0, ftdi_d_oe=0, ftdi_d_out=0, cpu_rdata=0, cpu_done=0, cpu_err=0, busy=0, data_wrh_n=1, synchronizer flops (rxf, txe)=1.
REQ-014 Reset mid-transaction SHALL immediately release all FT245 strobes to the inactive levels above; no cpu_done is issued.

Configuration
REQ-015 With FTDI245_TIMEOUT_EN defined, a request waiting in IDLE for TIMEOUT consecutive cycles SHALL produce cpu_done=1, cpu_err=1 with no bus activity; counter clears on request deassertion or transaction start.
REQ-016 Without FTDI245_TIMEOUT_EN, cpu_err SHALL be constant 0 and no timeout counter SHALL exist.

Structure
REQ-017 Package ftdi245_pkg SHALL hold the FSM state typedef, byte width constant and pulse-counter width constant (4 bits).
REQ-018 The 2-flop synchronizer SHALL be sub-module ftdi245_sync, instantiated twice.

Verification
REQ-019 Read: rxf_n=0, ftdi_d_in=0xA5, rd_req pulse-held -> rd_n low exactly 4 cycles, cpu_rdata=0xA5, cpu_done 1 cycle after 2 recovery cycles.
REQ-020 Write: txe_n=0, wdata=0x3C -> d_oe 1 cycle before wr, wr high 4 cycles, d_out=0x3C through wr fall +1, data_wrh_n and cpu_done pulse together.
REQ-021 Both requests with rxf_n=0, txe_n=0 -> read first, write starts cycle after cpu_done.
REQ-022 rd_req with rxf_n=1 for 50 cycles, then rxf_n=0 -> no strobe until 2 cycles after rxf_n falls, busy=0 while waiting.
REQ-023 rst_n asserted during WR_STROBE -> ftdi_wr=0, d_oe=0 same cycle, no cpu_done; with FTDI245_TIMEOUT_EN, TIMEOUT=16 and txe_n=1 -> cpu_done, cpu_err=1 at cycle 16.

Source files
------------

// File: rtl/ftdi245_pkg.sv
// Shared types and widths for the FT245 parallel bus master.
// FSM encoding, data byte width and strobe/recovery counter width.
package ftdi245_pkg;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_STROBE,
        RD_RECOV,
        WR_SETUP,
        WR_STROBE,
        WR_RECOV
    } state_t;

endpackage

// File: rtl/ftdi245_sync.sv
// Two-flop synchronizer for the FT245 status flags.
// Resets to 1 so a flag reads as "not ready" until sampled.
module ftdi245_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ftdi245_bus.sv
// FT245 asynchronous FIFO bus master: one byte read or write per request.
// Optional request timeout is enabled with FTDI245_TIMEOUT_EN.
module ftdi245_bus
    import ftdi245_pkg::*;
#(
    parameter int unsigned RD_PULSE = 4,
    parameter int unsigned WR_PULSE = 4,
    parameter int unsigned RECOVERY = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr_req,
    input  logic [BYTE_W-1:0] cpu_wdata,
    output logic [BYTE_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              busy,
    input  logic              ftdi_rxf_n,
    input  logic              ftdi_txe_n,
    input  logic [BYTE_W-1:0] ftdi_d_in,
    output logic [BYTE_W-1:0] ftdi_d_out,
    output logic              ftdi_d_oe,
    output logic              ftdi_rd_n,
    output logic              ftdi_wr,
    output logic              rxf,
    output logic              txe,
    output logic              data_wrh_n
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             rd_go;
    logic             wr_go;

    ftdi245_sync u_rxf_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ftdi_rxf_n),
        .q     (rxf)
    );

    ftdi245_sync u_txe_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ftdi_txe_n),
        .q     (txe)
    );

    // Read wins when both requests are serviceable.
    assign rd_go = cpu_rd_req && !rxf;
    assign wr_go = cpu_wr_req && !txe && !rd_go;

`ifdef FTDI245_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;
    assign cpu_err = err_q;
`else
    localparam int unsigned unused_timeout = TIMEOUT;
    assign cpu_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ftdi_rd_n  <= 1'b1;
            ftdi_wr    <= 1'b0;
            ftdi_d_oe  <= 1'b0;
            ftdi_d_out <= '0;
            cpu_rdata  <= '0;
            cpu_done   <= 1'b0;
            busy       <= 1'b0;
            data_wrh_n <= 1'b1;
`ifdef FTDI245_TIMEOUT_EN
            tmo_cnt    <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            cpu_done   <= 1'b0;
            data_wrh_n <= 1'b1;
`ifdef FTDI245_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (rd_go) begin
                        state     <= RD_STROBE;
                        ftdi_rd_n <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= CNT_W'(RD_PULSE - 1);
                    end else if (wr_go) begin
                        state      <= WR_SETUP;
                        ftdi_d_out <= cpu_wdata;
                        ftdi_d_oe  <= 1'b1;
                        busy       <= 1'b1;
                    end
`ifdef FTDI245_TIMEOUT_EN
                    // Counts only while a request is stuck waiting.
                    if (rd_go || wr_go || !(cpu_rd_req || cpu_wr_req)) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        tmo_cnt  <= '0;
                        cpu_done <= 1'b1;
                        err_q    <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                RD_STROBE: begin
                    if (cnt == '0) begin
                        state     <= RD_RECOV;
                        ftdi_rd_n <= 1'b1;
                        cpu_rdata <= ftdi_d_in;
                        cnt       <= CNT_W'(RECOVERY - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_RECOV: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        cpu_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_SETUP: begin
                    state   <= WR_STROBE;
                    ftdi_wr <= 1'b1;
                    cnt     <= CNT_W'(WR_PULSE - 1);
                end
                WR_STROBE: begin
                    if (cnt == '0) begin
                        state   <= WR_RECOV;
                        ftdi_wr <= 1'b0;
                        cnt     <= CNT_W'(RECOVERY - 1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_RECOV: begin
                    // Data stays driven for one hold cycle after WR falls.
                    ftdi_d_oe <= 1'b0;
                    if (cnt == '0) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cpu_done   <= 1'b1;
                        data_wrh_n <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
